// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// Build option: define TDM_DEMUX_PARITY_EN to add a trailing even-parity bit to every slot.
package tdm_demux_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned MISS_LIMIT = 2;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_deser.sv
// Per-slot serial-to-parallel converter: shift register, bit counter and optional parity accumulator.
// Build option: TDM_DEMUX_PARITY_EN appends one even-parity bit to each W-bit slot.
module tdm_deser
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample,
  input  logic         restart,
  input  logic         din,
  output logic         first_bit,
  output logic         word_done,
  output logic [W-1:0] word,
  output logic         par_ok
);

  localparam int unsigned L  = W + PAR_BITS;
  localparam int unsigned CW = $clog2(L);
  // Without parity the last data bit comes straight from din, so one bit less is stored.
  localparam int unsigned SW = (PAR_BITS != 0) ? W : W - 1;

  logic [CW-1:0] bit_cnt;
  logic [SW-1:0] shreg;
  logic          last;

  assign last      = (bit_cnt == CW'(L - 1));
  assign first_bit = (bit_cnt == '0);
  // A restart bit is always bit 0 of a fresh word, so it can never complete one.
  assign word_done = sample && !restart && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sample) begin
      if (restart) begin
        bit_cnt <= CW'(1);
        shreg   <= SW'(din);
      end else begin
        bit_cnt <= last ? '0 : bit_cnt + CW'(1);
        shreg   <= SW'({shreg, din});
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else if (sample) begin
      if (restart)   par_acc <= din;
      else if (last) par_acc <= 1'b0;
      else           par_acc <= par_acc ^ din;
    end
  end

  assign word   = shreg;
  assign par_ok = ~(par_acc ^ din);
`else
  assign word   = {shreg, din};
  assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer with frame-sync hunting, flywheel lock and realignment.
// Build option: TDM_DEMUX_PARITY_EN enables per-slot even parity checking and par_err.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                din,
  input  logic                frame_sync,
  output logic [NUM_CH*W-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                par_err
);

  state_t      state, state_next;
  slot_t       slot;
  logic [1:0]  miss, miss_next;
  logic        sample, restart, realign, slot_clr;
  logic        first_bit, word_done, par_ok;
  logic [W-1:0] word;
  logic        boundary;
  logic [NUM_CH-1:0] valid_next;
  logic        par_err_next;

  tdm_deser #(.W(W)) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .restart   (restart),
    .din       (din),
    .first_bit (first_bit),
    .word_done (word_done),
    .word      (word),
    .par_ok    (par_ok)
  );

  assign boundary = (slot == '0) && first_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    restart    = 1'b0;
    realign    = 1'b0;
    slot_clr   = 1'b0;
    miss_next  = miss;
    case (state)
      HUNT: begin
        if (ena && frame_sync) begin
          state_next = LOCK;
          sample     = 1'b1;
          restart    = 1'b1;
          slot_clr   = 1'b1;
          miss_next  = '0;
        end
      end
      LOCK: begin
        if (ena) begin
          if (frame_sync && !boundary) begin
            sample    = 1'b1;
            restart   = 1'b1;
            realign   = 1'b1;
            slot_clr  = 1'b1;
            miss_next = '0;
          end else if (boundary && frame_sync) begin
            sample    = 1'b1;
            miss_next = '0;
          end else if (boundary) begin
            // Second consecutive missing sync drops lock without sampling this bit.
            if (miss == 2'(MISS_LIMIT - 1)) begin
              state_next = HUNT;
              miss_next  = '0;
            end else begin
              sample    = 1'b1;
              miss_next = miss + 2'd1;
            end
          end else begin
            sample = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    valid_next   = '0;
    par_err_next = 1'b0;
    if (word_done) begin
      if (par_ok) valid_next[slot] = 1'b1;
      else        par_err_next     = 1'b1;
    end
  end

  assign locked = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      miss     <= '0;
      ch_valid <= '0;
      sync_err <= 1'b0;
      ch_data  <= '0;
    end else begin
      if (slot_clr)       slot <= '0;
      else if (word_done) slot <= slot + 2'd1;
      miss     <= miss_next;
      ch_valid <= valid_next;
      sync_err <= realign;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (valid_next[i]) ch_data[i*W +: W] <= word;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= par_err_next;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (W=8); parity steps follow TDM_DEMUX_PARITY_EN.
module tb_tdm_demux4;

  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic           din;
  logic           frame_sync;
  logic [4*W-1:0] ch_data;
  logic [3:0]     ch_valid;
  logic           locked;
  logic           sync_err;
  logic           par_err;

  int errors = 0;
  int checks = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .din        (din),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_cyc(input logic d, input logic fs, input logic e);
    din        = d;
    frame_sync = fs;
    ena        = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input string tag, input logic [7:0] v, input logic sync,
                           input logic good, input logic [3:0] exp_valid, input logic exp_serr);
    for (int i = 0; i < 8; i++) begin
      bit_cyc(v[7-i], sync && (i == 0), 1'b1);
      if (i == 0) begin
        check({tag, "_serr"},  32'(sync_err), 32'(exp_serr));
        check({tag, "_vdrop"}, 32'(ch_valid), 32'd0);
        check({tag, "_pdrop"}, 32'(par_err),  32'd0);
        if (sync) check({tag, "_lock"}, 32'(locked), 32'd1);
      end
    end
    if (PAR) bit_cyc(good ? ^v : ~^v, 1'b0, 1'b1);
    check({tag, "_valid"}, 32'(ch_valid), 32'(exp_valid));
    check({tag, "_perr"},  32'(par_err),  32'(PAR && !good));
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; ena = 1'b0; din = 1'b0; frame_sync = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_data",  ch_data, 32'h0);
    check("rst_valid", 32'(ch_valid), 32'd0);
    check("rst_lock",  32'(locked), 32'd0);
    check("rst_serr",  32'(sync_err), 32'd0);
    check("rst_perr",  32'(par_err), 32'd0);
    rst_n = 1'b1;

    // No sync yet: must stay hunting with no strobes
    for (int i = 0; i < 6; i++) bit_cyc(1'($urandom_range(1)), 1'b0, 1'b1);
    check("hunt_lock",  32'(locked), 32'd0);
    check("hunt_valid", 32'(ch_valid), 32'd0);

    // Basic frame A5,3C,FF,01
    send_word("f1s0", 8'hA5, 1'b1, 1'b1, 4'b0001, 1'b0);
    send_word("f1s1", 8'h3C, 1'b0, 1'b1, 4'b0010, 1'b0);
    send_word("f1s2", 8'hFF, 1'b0, 1'b1, 4'b0100, 1'b0);
    send_word("f1s3", 8'h01, 1'b0, 1'b1, 4'b1000, 1'b0);
    check("f1_data", ch_data, 32'h01FF3CA5);

    // Sync at slot 2 bit 5 realigns; ch2 keeps FF
    send_word("f2s0", 8'h11, 1'b1, 1'b1, 4'b0001, 1'b0);
    send_word("f2s1", 8'h22, 1'b0, 1'b1, 4'b0010, 1'b0);
    v = 8'h77;
    for (int i = 0; i < 5; i++) bit_cyc(v[7-i], 1'b0, 1'b1);
    send_word("ra_s0", 8'h9A, 1'b1, 1'b1, 4'b0001, 1'b1);
    check("ra_data", ch_data, 32'h01FF229A);
    send_word("ra_s1", 8'h5B, 1'b0, 1'b1, 4'b0010, 1'b0);
    send_word("ra_s2", 8'h6C, 1'b0, 1'b1, 4'b0100, 1'b0);
    send_word("ra_s3", 8'h7D, 1'b0, 1'b1, 4'b1000, 1'b0);
    check("ra_full", ch_data, 32'h7D6C5B9A);

    // Flywheel: first missing sync keeps decoding, second drops lock
    send_word("fw_s0", 8'h81, 1'b0, 1'b1, 4'b0001, 1'b0);
    check("fw_lock1", 32'(locked), 32'd1);
    send_word("fw_s1", 8'h42, 1'b0, 1'b1, 4'b0010, 1'b0);
    send_word("fw_s2", 8'h24, 1'b0, 1'b1, 4'b0100, 1'b0);
    send_word("fw_s3", 8'h18, 1'b0, 1'b1, 4'b1000, 1'b0);
    check("fw_data", ch_data, 32'h18244281);
    bit_cyc(1'b1, 1'b0, 1'b1);
    check("fw_lock2", 32'(locked), 32'd0);
    send_word("fw_dead", 8'hF0, 1'b0, 1'b1, 4'b0000, 1'b0);
    check("fw_hold", ch_data, 32'h18244281);
    check("fw_lock3", 32'(locked), 32'd0);

    // Three ena=0 cycles mid slot 1 (one carrying a stray frame_sync)
    send_word("st_s0", 8'hA5, 1'b1, 1'b1, 4'b0001, 1'b0);
    v = 8'h3C;
    for (int i = 0; i < 4; i++) bit_cyc(v[7-i], 1'b0, 1'b1);
    bit_cyc(1'b1, 1'b0, 1'b0);
    bit_cyc(1'b1, 1'b1, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    check("st_serr",  32'(sync_err), 32'd0);
    check("st_valid", 32'(ch_valid), 32'd0);
    check("st_lock",  32'(locked), 32'd1);
    for (int i = 4; i < 7; i++) bit_cyc(v[7-i], 1'b0, 1'b1);
    check("st_early", 32'(ch_valid), 32'd0);
    bit_cyc(v[0], 1'b0, 1'b1);
    if (PAR) bit_cyc(^v, 1'b0, 1'b1);
    check("st_s1_valid", 32'(ch_valid), 32'b0010);
    send_word("st_s2", 8'hFF, 1'b0, 1'b1, 4'b0100, 1'b0);
    send_word("st_s3", 8'h01, 1'b0, 1'b1, 4'b1000, 1'b0);
    check("st_data", ch_data, 32'h01FF3CA5);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on slot 1 leaves 3C in place
    send_word("pe_s0", 8'h11, 1'b1, 1'b1, 4'b0001, 1'b0);
    send_word("pe_s1", 8'h99, 1'b0, 1'b0, 4'b0000, 1'b0);
    check("pe_keep", 32'(ch_data[15:8]), 32'h3C);
    send_word("pe_s2", 8'h55, 1'b0, 1'b1, 4'b0100, 1'b0);
    send_word("pe_s3", 8'h66, 1'b0, 1'b1, 4'b1000, 1'b0);
    check("pe_data", ch_data, 32'h66553C11);
`endif

    // Asynchronous reset in the middle of slot 1
    send_word("rs_s0", 8'hA5, 1'b1, 1'b1, 4'b0001, 1'b0);
    v = 8'h3C;
    for (int i = 0; i < 5; i++) bit_cyc(v[7-i], 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_data",  ch_data, 32'h0);
    check("ar_valid", 32'(ch_valid), 32'd0);
    check("ar_lock",  32'(locked), 32'd0);
    check("ar_serr",  32'(sync_err), 32'd0);
    check("ar_perr",  32'(par_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) bit_cyc(1'($urandom_range(1)), 1'b0, 1'b1);
    check("ar_hunt_lock",  32'(locked), 32'd0);
    check("ar_hunt_valid", 32'(ch_valid), 32'd0);
    send_word("ar_relock", 8'h3C, 1'b1, 1'b1, 4'b0001, 1'b0);
    check("ar_relock_data", ch_data, 32'h0000003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
